// File: rtl/branch_predictor_pkg.sv
// Shared constants and types for the BTB-based branch predictor.
package branch_predictor_pkg;

  // Sequential fetch step in bytes
  localparam int unsigned PC_INC = 4;

  // Direction counter value after reset (strongly not-taken)
  localparam int unsigned CTR_RESET = 0;

  // BTB entry field layout when packed as {valid, tag, target, counter}
  localparam int unsigned FLD_CTR_LSB = 0;

  // Width-dependent helpers for the entry layout and counter values
  function automatic int unsigned fld_target_lsb(input int unsigned ctr_w);
    return FLD_CTR_LSB + ctr_w;
  endfunction

  function automatic int unsigned fld_tag_lsb(input int unsigned ctr_w, input int unsigned addr_w);
    return fld_target_lsb(ctr_w) + addr_w;
  endfunction

  function automatic int unsigned ctr_weak_taken(input int unsigned ctr_w);
    return 2 ** (ctr_w - 1);
  endfunction

  // BTB action taken at the resolve edge
  typedef enum logic [1:0] {
    UPD_NONE,
    UPD_BUMP,
    UPD_ALLOC,
    UPD_INVAL
  } upd_e;

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up/down counter next-state logic.
module sat_counter #(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0] i_cur,
  input  logic         i_en,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_next
);

  // Step by one in the requested direction, sticking at the rails
  always_comb begin
    o_next = i_cur;
    if (i_en) begin
      if (i_inc && !i_dec && (i_cur != '1)) begin
        o_next = i_cur + W'(1);
      end else if (i_dec && !i_inc && (i_cur != '0)) begin
        o_next = i_cur - W'(1);
      end
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters, D-stage mispredict
// detection and saturating statistics.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INDEX_W = 4,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned STAT_W  = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] pcF,
  input  logic              stallD,
  input  logic              flushD,
  output logic              predTakenF,
  output logic [ADDR_W-1:0] predTargetF,
  input  logic              resolveD,
  input  logic              isBranchD,
  input  logic              takenD,
  input  logic [ADDR_W-1:0] targetD,
  output logic              mispredictD,
  output logic [ADDR_W-1:0] redirectPCD,
  output logic [STAT_W-1:0] branchCount,
  output logic [STAT_W-1:0] mispredictCount
);

  localparam int unsigned ENTRIES = 2 ** INDEX_W;
  localparam int unsigned TAG_W   = ADDR_W - INDEX_W - 2;

  logic              r_valid  [ENTRIES];
  logic [TAG_W-1:0]  r_tag    [ENTRIES];
  logic [ADDR_W-1:0] r_target [ENTRIES];
  logic [CTR_W-1:0]  r_ctr    [ENTRIES];

  logic              r_validS;
  logic [ADDR_W-1:0] r_pcS;
  logic              r_predTakenS;
  logic [ADDR_W-1:0] r_predTargetS;

  logic [STAT_W-1:0] r_branchCount;
  logic [STAT_W-1:0] r_mispredictCount;

  logic [INDEX_W-1:0] w_idxF;
  logic [TAG_W-1:0]   w_tagF;
  logic               w_hitF;
  logic [INDEX_W-1:0] w_idxS;
  logic [TAG_W-1:0]   w_tagS;
  logic               w_hitS;
  logic               w_upd;
  upd_e               w_act;
  logic [CTR_W-1:0]   w_ctrNext;
  logic [STAT_W-1:0]  w_branchNext;
  logic [STAT_W-1:0]  w_mispNext;

  assign w_idxF = pcF[INDEX_W+1:2];
  assign w_tagF = pcF[ADDR_W-1:INDEX_W+2];
  assign w_idxS = r_pcS[INDEX_W+1:2];
  assign w_tagS = r_pcS[ADDR_W-1:INDEX_W+2];

  // Fetch lookup: hit and predicted next PC
  always_comb begin
    w_hitF      = r_valid[w_idxF] && (r_tag[w_idxF] == w_tagF);
    predTakenF  = w_hitF && r_ctr[w_idxF][CTR_W-1];
    predTargetF = predTakenF ? r_target[w_idxF] : (pcF + ADDR_W'(PC_INC));
  end

  // D-stage compare of the shadowed prediction against the resolved outcome
  always_comb begin
    mispredictD = 1'b0;
    redirectPCD = '0;
    if (r_validS && resolveD) begin
      if (isBranchD && takenD && (!r_predTakenS || (r_predTargetS != targetD))) begin
        mispredictD = 1'b1;
        redirectPCD = targetD;
      end else if (r_predTakenS && (!isBranchD || !takenD)) begin
        mispredictD = 1'b1;
        redirectPCD = r_pcS + ADDR_W'(PC_INC);
      end
    end
  end

  // Choose the BTB action for the resolving instruction
  always_comb begin
    w_upd  = r_validS && resolveD && !stallD;
    w_hitS = r_valid[w_idxS] && (r_tag[w_idxS] == w_tagS);
    w_act  = UPD_NONE;
    if (w_upd) begin
      if (isBranchD) begin
        if (w_hitS)      w_act = UPD_BUMP;
        else if (takenD) w_act = UPD_ALLOC;
      end else if (w_hitS) begin
        w_act = UPD_INVAL;
      end
    end
  end

  sat_counter #(.W(CTR_W)) u_dir_ctr (
    .i_cur  (r_ctr[w_idxS]),
    .i_en   (1'b1),
    .i_inc  (takenD),
    .i_dec  (!takenD),
    .o_next (w_ctrNext)
  );

  sat_counter #(.W(STAT_W)) u_branch_ctr (
    .i_cur  (r_branchCount),
    .i_en   (w_upd),
    .i_inc  (isBranchD),
    .i_dec  (1'b0),
    .o_next (w_branchNext)
  );

  sat_counter #(.W(STAT_W)) u_misp_ctr (
    .i_cur  (r_mispredictCount),
    .i_en   (w_upd),
    .i_inc  (mispredictD),
    .i_dec  (1'b0),
    .o_next (w_mispNext)
  );

  // BTB storage update at the resolve edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CTR_W'(CTR_RESET);
      end
    end else begin
      case (w_act)
        UPD_BUMP: begin
          r_ctr[w_idxS] <= w_ctrNext;
          if (takenD) r_target[w_idxS] <= targetD;
        end
        UPD_ALLOC: begin
          r_valid[w_idxS]  <= 1'b1;
          r_tag[w_idxS]    <= w_tagS;
          r_target[w_idxS] <= targetD;
          r_ctr[w_idxS]    <= CTR_W'(ctr_weak_taken(CTR_W));
        end
        UPD_INVAL: r_valid[w_idxS] <= 1'b0;
        default: ;
      endcase
    end
  end

  // F->D shadow of the prediction; flush wins over stall
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_validS      <= 1'b0;
      r_pcS         <= '0;
      r_predTakenS  <= 1'b0;
      r_predTargetS <= '0;
    end else if (flushD) begin
      r_validS     <= 1'b0;
      r_predTakenS <= 1'b0;
    end else if (!stallD) begin
      r_validS      <= 1'b1;
      r_pcS         <= pcF;
      r_predTakenS  <= predTakenF;
      r_predTargetS <= predTargetF;
    end
  end

  // Statistics registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_branchCount     <= '0;
      r_mispredictCount <= '0;
    end else begin
      r_branchCount     <= w_branchNext;
      r_mispredictCount <= w_mispNext;
    end
  end

  assign branchCount     = r_branchCount;
  assign mispredictCount = r_mispredictCount;

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised successor to the fixed branch/jump controller: a direct-mapped branch target buffer (BTB) with saturating direction counters.
- The Fetch stage gets a predicted next PC in the same cycle.
- The block tracks each prediction through its own F->D shadow register.
- In Decode it compares the prediction against the resolved outcome and issues a single-cycle redirect on a mispredict, plus saturating statistics counters.

Parameters:
- ADDR_W, 32, PC/target width.
- INDEX_W, 4, BTB index bits; entries = 2**INDEX_W, indexed by pc[INDEX_W+1:2].
- CTR_W, 2, direction counter width; predict taken when MSB=1.
- STAT_W, 32, width of statistics counters.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- pcF  in  ADDR_W  PC of the instruction in Fetch.
- stallD  in  1  hold the D-stage shadow register (same signal as the F->D register stall).
- flushD  in  1  invalidate the D-stage shadow register (same signal as the F->D register flush).
- predTakenF  out  1  BTB hit AND counter MSB=1.
- predTargetF  out  ADDR_W  predicted target; equals pcF+4 when predTakenF=0.
- resolveD  in  1  the D-stage instruction is valid and resolved this cycle.
- isBranchD  in  1  the D-stage instruction is a branch/jump/jr.
- takenD  in  1  resolved direction (1 for jumps).
- targetD  in  ADDR_W  resolved target.
- mispredictD  out  1  redirect request, combinational from D state.
- redirectPCD  out  ADDR_W  correct next PC when mispredictD=1; 0 otherwise.
- branchCount  out  STAT_W  resolved branches, saturating.
- mispredictCount  out  STAT_W  mispredicts, saturating.

Behaviour:
- BTB entry: valid, tag = pc[ADDR_W-1:INDEX_W+2], target, counter.
- Lookup is combinational on pcF. Hit = valid && tag match.
- Shadow register {validS, pcS, predTakenS, predTargetS} loads pcF plus the prediction each edge.
  - flushD: validS <= 0. Flush has priority over stall.
  - stallD: hold.
  - Otherwise: validS <= 1.
- Mispredict is evaluated only when validS && resolveD:
  - isBranchD && takenD && (!predTakenS || predTargetS != targetD) -> mispredictD=1, redirectPCD=targetD.
  - predTakenS && (!isBranchD || !takenD) -> mispredictD=1, redirectPCD=pcS+4.
  - Otherwise mispredictD=0.
- BTB update happens at the edge where validS && resolveD && !stallD, at index pcS[INDEX_W+1:2]:
  - isBranchD, hit: counter +1 if taken, -1 if not taken, saturating at 0 and 2**CTR_W-1. Target <= targetD when taken.
  - isBranchD, miss, taken: allocate; valid=1, tag, target=targetD, counter=2**(CTR_W-1) (weakly taken). Any existing entry at that index is overwritten.
  - isBranchD, miss, not taken: no change.
  - !isBranchD with a hit on a stale entry: valid <= 0.
- Statistics, on the same update condition:
  - branchCount +1 when isBranchD.
  - mispredictCount +1 when mispredictD.
  - Both hold at all-ones.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update contents (read-before-write).
- A stall with resolveD=1 performs no update. The update happens once, at the edge that releases the stall.
- Reset (asynchronous, any time, including mid-stall):
  - All valid bits 0, counters 0, targets/tags 0.
  - validS=0, predTakenS=0.
  - Stat counters 0.
  - Outputs: predTakenF=0, predTargetF=pcF+4, mispredictD=0, redirectPCD=0.
- Latency: prediction in 0 cycles. Mispredict one cycle after fetch, in D. BTB state is visible to a lookup on the cycle after the update edge.

Decomposition:
- Shared package constants: PC_INC=4, counter reset/weak-taken values, BTB entry field offsets.
- One sub-module, sat_counter (parametrised width, inc/dec/en, saturating). Instantiate it for the direction counters' next-state logic and for both stat counters.

Test Plan:
- Reset, then pcF=0x40 -> predTakenF=0, predTargetF=0x44. Both counts 0.
- Resolve taken branch at 0x40 -> target 0x80 (cold) -> mispredictD=1, redirectPCD=0x80, mispredictCount=1. Next fetch of 0x40 -> predTakenF=1, predTargetF=0x80.
- Same branch resolved not-taken twice -> first resolve: mispredictD=1, redirectPCD=0x44, counter 10->01. Next fetch predicts not-taken; second resolve: no mispredict, counter 00.
- Taken 4x -> counter saturates at 11. A fifth taken leaves it at 11. branchCount increments each time.
- Aliasing: 0x40 allocated, then taken branch at 0x80 (same index, different tag) -> overwrites entry. Fetch 0x40 -> predTakenF=0.
- stallD held 3 cycles with resolveD=1 -> single update and single count increment. flushD during pending resolve -> no update, mispredictD=0. reset_n pulsed mid-stall -> all outputs at reset values immediately.
